fpu_muldiv: RTL and testbench
=============================

# fpu_muldiv

- Responder end of the one-hot FPU opcode interface.
- Accepts a single-cycle one-hot `opcode` pulse with operands `x1`/`x2`. Runs FP multiply, divide or square root on an iterative engine, then returns `y`/`ovf`/`unf` with a one-cycle `out_valid` pulse.
- Sits behind the ALU-side FPU issue logic, in the position of `fpu_top`, and serves the multi-cycle opcodes.

## Interface
- No parameters. Latencies and opcode bit indices come from `fpu_pkg`.
- `sys_clk`  in  1  Single clock; all state changes on its rising edge.
- `rst`  in  1  Reset. Synchronous and active-high.
- `opcode`  in  10  One-hot operation select.
  - Nonzero for exactly one cycle means start.
  - bit2 = fmul, bit3 = fdiv, bit4 = fsqrt.
  - All other bits are unsupported.
- `x1`  in  32  IEEE-754 single-precision operand A. Sampled in the start cycle.
- `x2`  in  32  Operand B. Sampled in the start cycle; ignored for fsqrt.
- `y`  out  32  Result. Valid with `out_valid`; held until the next accepted start.
- `ovf`  out  1  Overflow flag. Valid with `out_valid`; held with `y`.
- `unf`  out  1  Underflow flag. Valid with `out_valid`; held with `y`.
- `out_valid`  out  1  One-cycle completion pulse.

## Operation
- **States:** IDLE, ITER, PACK, DONE.
- **IDLE:**
  - Nonzero `opcode` with exactly one supported bit set: unpack and latch operands, load the iteration counter, go to ITER.
  - Special-case operands: compute the result directly and go to PACK.
  - Unsupported or multi-bit opcode: go to DONE with `y`=0, `ovf`=`unf`=0.
- **ITER:** one engine step per cycle (result bit-width and semantics below); go to PACK when the counter expires.
  - fmul: 24 shift-add steps.
  - fdiv: 25 restoring quotient bits.
  - fsqrt: 25 restoring root bits.
- **PACK:** normalize, truncate (round toward zero), bias exponent, classify. Go to DONE.
- **DONE:** `out_valid`=1 for this cycle only, then go to IDLE.
- **Start while busy:** `opcode` is ignored in ITER, PACK and DONE. No queueing, no error.
- **Number format:**
  - Subnormal inputs are flushed to signed zero.
  - Subnormal results are flushed to signed zero with `unf`=1.
- **Result sign:** XOR of operand signs for fmul/fdiv; sign of `x1` for fsqrt.
- **Exponent arithmetic:** done in 10-bit signed. Biased result exponent after normalization:
  - > 254: `y` = signed infinity, `ovf`=1.
  - < 1 and value nonzero: `y` = signed zero, `unf`=1.
- **Special cases** (via PACK, `ovf`=`unf`=0):
  - Any NaN input, 0×inf, 0/0, inf/inf, or sqrt of a negative nonzero: `y` = 0x7FC00000.
  - Nonzero/0: signed infinity.
  - x/inf: signed zero.
  - Multiplication or division with a zero operand: signed zero.
  - sqrt(±0) = ±0; sqrt(+inf) = +inf.
- **fsqrt exponent:** an odd unbiased exponent pre-shifts the mantissa left by 1 before iteration.

## Timing
- Start cycle is cycle 0. `out_valid` is asserted in cycle L.
  - fmul: L=26.
  - fdiv: L=27.
  - fsqrt: L=27.
  - Special case: L=2.
  - Unsupported or multi-bit opcode: L=1.
- The earliest accepted new start is the cycle after DONE.
- `y`/`ovf`/`unf` change only on the DONE-entry edge and stay stable until the next DONE.
- **Reset values:** `y`=0, `ovf`=0, `unf`=0, `out_valid`=0, state IDLE.
- **Reset mid-operation:** the operation is aborted with no `out_valid` pulse; outputs return to reset values on the next edge.
- **Reset asserted together with a start:** reset wins; the start is dropped.

## Configuration
- Macro: `FPU_MULDIV_SQRT_EN`.
- **Defined:** opcode bit4 performs fsqrt as specified.
- **Undefined:** the fsqrt datapath is not compiled. Bit4 is handled as unsupported: L=1, `y`=0, flags 0.

## Structure
- **`fpu_pkg` contents:**
  - Opcode bit indices.
  - State enum.
  - Iteration counts (24/25/25).
  - Canonical NaN 0x7FC00000.
  - Exponent bias 127 and max biased exponent 254.
  - Infinity constants.
- **Sub-module `fpu_pack`:** combinational normalize / truncate / overflow-underflow classify. Used in PACK.
- **Iterative engine:** stays in `fpu_muldiv`, shared remainder/accumulator registers across the three ops.

## Test plan
- fmul 0x40000000 × 0x40400000 -> `y`=0x40C00000, `ovf`=`unf`=0, `out_valid` in cycle 26 only.
- fdiv 0x3F800000 / 0x40400000 -> `y`=0x3EAAAAAA (truncated), cycle 27.
- fsqrt 0x40000000 -> `y`=0x3FB504F3; fsqrt 0xBF800000 -> 0x7FC00000 at cycle 2.
  - Without `FPU_MULDIV_SQRT_EN`: `y`=0 at cycle 1.
- Overflow/underflow:
  - fmul 0x7F000000 × 0x7F000000 -> 0x7F800000, `ovf`=1, cycle 26.
  - fmul 0x00800000 × 0x00800000 -> 0x00000000, `unf`=1.
- Special case and illegal opcodes:
  - fdiv 0x3F800000 / 0x00000000 -> 0x7F800000 at cycle 2.
  - `opcode`=0x00C -> `y`=0 at cycle 1.
- fmul started, second `opcode` pulse at cycle 5 -> ignored, single `out_valid` at 26.
- Reset at cycle 10 -> no pulse, outputs 0; new fdiv afterwards completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the multi-cycle FPU responder (fpu_muldiv):
// opcode bit positions, FSM states, iteration counts, IEEE-754 constants
// and an operand unpack helper.
package fpu_pkg;

    // One-hot opcode bit positions
    localparam int OPC_W     = 10;
    localparam int OPC_FMUL  = 2;
    localparam int OPC_FDIV  = 3;
    localparam int OPC_FSQRT = 4;

    // Engine steps per operation
    localparam logic [4:0] ITER_MUL  = 5'd24;
    localparam logic [4:0] ITER_DIV  = 5'd25;
    localparam logic [4:0] ITER_SQRT = 5'd25;

    // IEEE-754 single-precision constants
    localparam logic [31:0]       FP_QNAN  = 32'h7FC0_0000;
    localparam logic [31:0]       FP_PINF  = 32'h7F80_0000;
    localparam logic [31:0]       FP_NINF  = 32'hFF80_0000;
    localparam logic signed [9:0] EXP_BIAS = 10'sd127;
    localparam logic signed [9:0] EXP_MAX  = 10'sd254;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_PACK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_DIV,
        OP_SQRT
    } op_t;

    // Unpacked operand; subnormals are reported as zero
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        zero;
        logic        inf;
        logic        nan;
    } fp_unp_t;

    function automatic fp_unp_t fp_unpack(input logic [31:0] x);
        fp_unp_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.mant = {1'b1, x[22:0]};
        u.zero = (x[30:23] == 8'h00);
        u.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        u.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        return u;
    endfunction

    function automatic logic [31:0] fp_inf(input logic s);
        return s ? FP_NINF : FP_PINF;
    endfunction

endpackage

// File: rtl/fpu_pack.sv
// Result packer: takes a 25-bit mantissa whose leading one sits at bit 24
// or bit 23, normalizes it, truncates toward zero, applies the exponent
// adjustment and classifies overflow / underflow.
module fpu_pack
    import fpu_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [24:0]       i_mant,
    output logic [31:0]       o_y,
    output logic              o_ovf,
    output logic              o_unf
);

    logic signed [9:0] w_exp;
    logic [22:0]       w_frac;

    // Normalize by at most one position, then saturate or flush
    always_comb begin
        w_exp  = i_exp + (i_mant[24] ? 10'sd1 : 10'sd0);
        w_frac = i_mant[24] ? i_mant[23:1] : i_mant[22:0];
        o_ovf  = 1'b0;
        o_unf  = 1'b0;
        if (w_exp > EXP_MAX) begin
            o_y   = fp_inf(i_sign);
            o_ovf = 1'b1;
        end else if (w_exp < 10'sd1) begin
            o_y   = {i_sign, 31'h0};
            o_unf = 1'b1;
        end else begin
            o_y   = {i_sign, w_exp[7:0], w_frac};
        end
    end

endmodule

// File: rtl/fpu_muldiv.sv
// Multi-cycle FPU responder: fmul / fdiv / fsqrt on a shared iterative
// engine (shift-add multiply, restoring divide, restoring square root).
// Optional feature macro: FPU_MULDIV_SQRT_EN enables the fsqrt datapath;
// without it opcode bit 4 is treated as unsupported.
module fpu_muldiv
    import fpu_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    output logic [31:0]      y,
    output logic             ovf,
    output logic             unf,
    output logic             out_valid
);

    state_t            r_state;
    op_t               r_op;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [49:0]       r_acc;   // mul accumulator / div and sqrt remainder
    logic [49:0]       r_a;     // multiplicand / divisor / radicand shifter
    logic [24:0]       r_q;     // multiplier / quotient / root
    logic [4:0]        r_cnt;
    logic              r_spec;
    logic [31:0]       r_spec_y;
    logic [31:0]       r_y;
    logic              r_ovf;
    logic              r_unf;
    logic              r_out_valid;

    fp_unp_t           w_a;
    fp_unp_t           w_b;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_is_sqrt;
    logic              w_legal;
    logic              w_sign;
    logic              w_spec;
    logic [31:0]       w_spec_y;
    logic signed [9:0] w_ea;
    logic signed [9:0] w_eb;
    logic signed [9:0] w_exp_mul;
    logic signed [9:0] w_exp_div;
    logic [49:0]       w_mul_acc;
    logic              w_div_ge;
    logic [49:0]       w_div_rem;
    logic [24:0]       w_pk_mant;
    logic [31:0]       w_pk_y;
    logic              w_pk_ovf;
    logic              w_pk_unf;
`ifdef FPU_MULDIV_SQRT_EN
    logic signed [9:0] w_e_unb;
    logic signed [9:0] w_exp_sqrt;
    logic [49:0]       w_sq_rem;
    logic [49:0]       w_sq_trial;
    logic              w_sq_ge;
`endif

    assign y         = r_y;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign out_valid = r_out_valid;

    // Opcode decode, operand unpack and result exponent per operation
    always_comb begin
        w_a       = fp_unpack(x1);
        w_b       = fp_unpack(x2);
        w_is_mul  = (opcode == (10'd1 << OPC_FMUL));
        w_is_div  = (opcode == (10'd1 << OPC_FDIV));
`ifdef FPU_MULDIV_SQRT_EN
        w_is_sqrt = (opcode == (10'd1 << OPC_FSQRT));
`else
        w_is_sqrt = 1'b0;
`endif
        w_legal   = w_is_mul || w_is_div || w_is_sqrt;
        w_sign    = w_is_sqrt ? w_a.sign : (w_a.sign ^ w_b.sign);
        w_ea      = signed'({2'b00, w_a.exp});
        w_eb      = signed'({2'b00, w_b.exp});
        // product carries two integer bits; packer adds one when bit 47 is set
        w_exp_mul = w_ea + w_eb - EXP_BIAS;
        // quotient sits one position above the packer's reference point
        w_exp_div = w_ea - w_eb + EXP_BIAS - 10'sd1;
`ifdef FPU_MULDIV_SQRT_EN
        // floor(E/2); odd E is absorbed by pre-shifting the mantissa
        w_e_unb    = w_ea - EXP_BIAS;
        w_exp_sqrt = (w_e_unb >>> 1) + EXP_BIAS - 10'sd1;
`endif
    end

    // Special-operand results that bypass the iterative engine
    always_comb begin
        w_spec   = 1'b0;
        w_spec_y = '0;
        if (w_is_mul) begin
            if (w_a.nan || w_b.nan || (w_a.zero && w_b.inf) || (w_a.inf && w_b.zero)) begin
                w_spec = 1'b1; w_spec_y = FP_QNAN;
            end else if (w_a.inf || w_b.inf) begin
                w_spec = 1'b1; w_spec_y = fp_inf(w_sign);
            end else if (w_a.zero || w_b.zero) begin
                w_spec = 1'b1; w_spec_y = {w_sign, 31'h0};
            end
        end else if (w_is_div) begin
            if (w_a.nan || w_b.nan || (w_a.zero && w_b.zero) || (w_a.inf && w_b.inf)) begin
                w_spec = 1'b1; w_spec_y = FP_QNAN;
            end else if (w_b.zero || w_a.inf) begin
                w_spec = 1'b1; w_spec_y = fp_inf(w_sign);
            end else if (w_b.inf || w_a.zero) begin
                w_spec = 1'b1; w_spec_y = {w_sign, 31'h0};
            end
        end
`ifdef FPU_MULDIV_SQRT_EN
        else if (w_is_sqrt) begin
            if (w_a.nan) begin
                w_spec = 1'b1; w_spec_y = FP_QNAN;
            end else if (w_a.zero) begin
                w_spec = 1'b1; w_spec_y = {w_a.sign, 31'h0};
            end else if (w_a.sign) begin
                w_spec = 1'b1; w_spec_y = FP_QNAN;
            end else if (w_a.inf) begin
                w_spec = 1'b1; w_spec_y = FP_PINF;
            end
        end
`endif
    end

    // Next-step values of the shared engine registers
    always_comb begin
        w_mul_acc  = {r_acc[48:0], 1'b0} + (r_q[23] ? {26'h0, r_a[23:0]} : 50'h0);
        w_div_ge   = (r_acc >= r_a);
        w_div_rem  = w_div_ge ? (r_acc - r_a) : r_acc;
`ifdef FPU_MULDIV_SQRT_EN
        w_sq_rem   = {r_acc[47:0], r_a[49:48]};
        w_sq_trial = {23'h0, r_q, 2'b01};
        w_sq_ge    = (w_sq_rem >= w_sq_trial);
`endif
        w_pk_mant  = (r_op == OP_MUL) ? r_acc[47:23] : r_q;
    end

    fpu_pack u_pack (
        .i_sign (r_sign),
        .i_exp  (r_exp),
        .i_mant (w_pk_mant),
        .o_y    (w_pk_y),
        .o_ovf  (w_pk_ovf),
        .o_unf  (w_pk_unf)
    );

    // Operand latch on start, then one engine step per ITER cycle
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (opcode != '0 && w_legal) begin
                        r_spec   <= w_spec;
                        r_spec_y <= w_spec_y;
                        r_sign   <= w_sign;
                        if (w_is_mul) begin
                            r_op  <= OP_MUL;
                            r_exp <= w_exp_mul;
                            r_acc <= '0;
                            r_a   <= {26'h0, w_a.mant};
                            r_q   <= {1'b0, w_b.mant};
                            r_cnt <= ITER_MUL;
                        end else if (w_is_div) begin
                            r_op  <= OP_DIV;
                            r_exp <= w_exp_div;
                            r_acc <= {26'h0, w_a.mant};
                            r_a   <= {26'h0, w_b.mant};
                            r_q   <= '0;
                            r_cnt <= ITER_DIV;
                        end
`ifdef FPU_MULDIV_SQRT_EN
                        else begin
                            r_op  <= OP_SQRT;
                            r_exp <= w_exp_sqrt;
                            r_acc <= '0;
                            r_a   <= {(w_e_unb[0] ? {w_a.mant, 1'b0} : {1'b0, w_a.mant}), 25'h0};
                            r_q   <= '0;
                            r_cnt <= ITER_SQRT;
                        end
`endif
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt - 5'd1;
                    case (r_op)
                        OP_MUL: begin
                            r_acc <= w_mul_acc;
                            r_q   <= {r_q[23:0], 1'b0};
                        end
                        OP_DIV: begin
                            r_acc <= {w_div_rem[48:0], 1'b0};
                            r_q   <= {r_q[23:0], w_div_ge};
                        end
`ifdef FPU_MULDIV_SQRT_EN
                        OP_SQRT: begin
                            r_acc <= w_sq_ge ? (w_sq_rem - w_sq_trial) : w_sq_rem;
                            r_q   <= {r_q[23:0], w_sq_ge};
                            r_a   <= {r_a[47:0], 2'b00};
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered result, flags and completion pulse
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_y         <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (opcode != '0) begin
                        if (!w_legal) begin
                            r_y         <= '0;
                            r_ovf       <= 1'b0;
                            r_unf       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_spec) begin
                            r_state <= ST_PACK;
                        end else begin
                            r_state <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    if (r_cnt == 5'd1)
                        r_state <= ST_PACK;
                end
                ST_PACK: begin
                    if (r_spec) begin
                        r_y   <= r_spec_y;
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                    end else begin
                        r_y   <= w_pk_y;
                        r_ovf <= w_pk_ovf;
                        r_unf <= w_pk_unf;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_muldiv.sv
// Directed bench for fpu_muldiv: vector table of operations with
// hand-computed results and latencies, plus busy-start, reset-abort and
// reset-with-start sequences.
module tb_fpu_muldiv;

    localparam logic [9:0] OPM = 10'h004;
    localparam logic [9:0] OPD = 10'h008;
    localparam logic [9:0] OPS = 10'h010;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [9:0]  opcode;
    logic [31:0] x1, x2;
    logic [31:0] y;
    logic        ovf, unf, out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    fpu_muldiv dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .opcode    (opcode),
        .x1        (x1),
        .x2        (x2),
        .y         (y),
        .ovf       (ovf),
        .unf       (unf),
        .out_valid (out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string       name;
        logic [9:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ey;
        logic        eovf;
        logic        eunf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start one op, watch 32 cycles; operands are scrambled after the start
    task automatic run_op(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [9:0] inj_op, input int inj_cyc,
                          output int npulse, output int cyc,
                          output logic [31:0] gy, output logic govf, output logic gunf);
        npulse = 0; cyc = -1; gy = '0; govf = 1'b0; gunf = 1'b0;
        @(negedge sys_clk);
        opcode = op; x1 = a; x2 = b;
        for (int c = 1; c <= 32; c++) begin
            @(negedge sys_clk);
            opcode = '0;
            x1 = 32'hDEAD_BEEF; x2 = 32'h1234_5678;
            if (c == inj_cyc) opcode = inj_op;
            if (out_valid) begin
                npulse++;
                if (cyc < 0) begin
                    cyc = c; gy = y; govf = ovf; gunf = unf;
                end
            end
        end
    endtask

    task automatic check_vec(input vec_t v, input logic [9:0] inj_op, input int inj_cyc);
        int np, cy;
        logic [31:0] gy;
        logic go, gu;
        run_op(v.op, v.a, v.b, inj_op, inj_cyc, np, cy, gy, go, gu);
        check({v.name, " pulses"}, 32'(np), 32'd1);
        check({v.name, " latency"}, 32'(cy), 32'(v.lat));
        check({v.name, " y"}, gy, v.ey);
        check({v.name, " ovf"}, {31'h0, go}, {31'h0, v.eovf});
        check({v.name, " unf"}, {31'h0, gu}, {31'h0, v.eunf});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int np;
        vec_t v;

        vecs.push_back('{"mul 2x3",        OPM, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 26});
        vecs.push_back('{"mul -2x1.5",     OPM, 32'hC000_0000, 32'h3FC0_0000, 32'hC040_0000, 1'b0, 1'b0, 26});
        vecs.push_back('{"mul ovf",        OPM, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0, 26});
        vecs.push_back('{"mul unf",        OPM, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, 26});
        vecs.push_back('{"mul 0xinf",      OPM, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"mul subn x 2",   OPM, 32'h8000_0001, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"div 1/3",        OPD, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 27});
        vecs.push_back('{"div 6/2",        OPD, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 27});
        vecs.push_back('{"div 1/0",        OPD, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"div 1/-inf",     OPD, 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"div 0/0",        OPD, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2});
`ifdef FPU_MULDIV_SQRT_EN
        vecs.push_back('{"sqrt 2",         OPS, 32'h4000_0000, 32'h0,         32'h3FB5_04F3, 1'b0, 1'b0, 27});
        vecs.push_back('{"sqrt 4",         OPS, 32'h4080_0000, 32'h0,         32'h4000_0000, 1'b0, 1'b0, 27});
        vecs.push_back('{"sqrt -1",        OPS, 32'hBF80_0000, 32'h0,         32'h7FC0_0000, 1'b0, 1'b0, 2});
`else
        vecs.push_back('{"sqrt 2 off",     OPS, 32'h4000_0000, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1});
        vecs.push_back('{"sqrt -1 off",    OPS, 32'hBF80_0000, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1});
`endif
        vecs.push_back('{"opc 0x00C",      10'h00C, 32'h4000_0000, 32'h4040_0000, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{"opc 0x001",      10'h001, 32'h4000_0000, 32'h4040_0000, 32'h0, 1'b0, 1'b0, 1});

        // Reset state
        rst = 1'b1; opcode = '0; x1 = '0; x2 = '0;
        repeat (3) @(negedge sys_clk);
        check("reset y", y, 32'h0);
        check("reset flags/valid", {29'h0, ovf, unf, out_valid}, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) check_vec(vecs[i], 10'h000, 0);

        // Second opcode pulse while busy is ignored
        v = '{"mul busy", OPM, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 26};
        check_vec(v, OPD, 5);

        // Reset in cycle 10 of an fmul: no pulse, outputs cleared
        @(negedge sys_clk);
        opcode = OPM; x1 = 32'h4000_0000; x2 = 32'h4040_0000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge sys_clk);
            opcode = '0;
        end
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("abort y", y, 32'h0);
        check("abort flags", {30'h0, ovf, unf}, 32'h0);
        np = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge sys_clk);
            if (out_valid) np++;
        end
        check("abort pulses", 32'(np), 32'd0);

        v = '{"div after reset", OPD, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 27};
        check_vec(v, 10'h000, 0);

        // Reset asserted together with a start: start dropped, y stays cleared
        @(negedge sys_clk);
        rst = 1'b1; opcode = OPM; x1 = 32'h4000_0000; x2 = 32'h4040_0000;
        @(negedge sys_clk);
        rst = 1'b0; opcode = '0;
        np = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge sys_clk);
            if (out_valid) np++;
        end
        check("rst+start pulses", 32'(np), 32'd0);
        check("rst+start y", y, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
